// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder.
// Contents: opcode constants, funct7 values, default NOP word,
// loader state encoding and the instruction format selector.
package instr_encoder_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    localparam logic [6:0]  FUNCT7_ALT   = 7'b0100000;
    localparam logic [6:0]  FUNCT7_ZERO  = 7'b0000000;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // FMT_ISH is the I-type shift form (funct7 + shamt).
    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_ISH = 3'd2,
        FMT_S   = 3'd3,
        FMT_B   = 3'd4,
        FMT_U   = 3'd5,
        FMT_J   = 3'd6
    } fmt_e;

endpackage

// File: rtl/instr_encoder_imm_packer.sv
// Scatters a decoder-form immediate into its machine-word bit positions.
// Ports: fmt (format select), imm (decoder-form immediate),
//        imm_bits (immediate bits in place, all other bits zero),
//        range_ok (immediate representable in the format).
// Config: ENCODER_RANGE_CHECK_EN enables the representability check;
//         otherwise range_ok is constant 1 and excess bits are dropped.
module instr_encoder_imm_packer
    import instr_encoder_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [31:0] imm,
    output logic [31:0] imm_bits,
    output logic        range_ok
);

    // Bit placement per format.
    always_comb begin
        imm_bits = '0;
        unique case (fmt)
            FMT_I:   imm_bits = {imm[11:0], 20'b0};
            FMT_ISH: imm_bits = {7'b0, imm[4:0], 20'b0};
            FMT_S:   imm_bits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
            FMT_B:   imm_bits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
            FMT_U:   imm_bits = {imm[31:12], 12'b0};
            FMT_J:   imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
            default: imm_bits = '0;
        endcase
    end

`ifdef ENCODER_RANGE_CHECK_EN
    // Signed widths must sign-extend; branch/jump offsets must be even.
    always_comb begin
        range_ok = 1'b1;
        unique case (fmt)
            FMT_I, FMT_S: range_ok = (&imm[31:11]) | ~(|imm[31:11]);
            FMT_ISH:      range_ok = ~(|imm[31:5]);
            FMT_B:        range_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
            FMT_U:        range_ok = ~(|imm[11:0]);
            FMT_J:        range_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
            default:      range_ok = 1'b1;
        endcase
    end
`else
    logic unused_imm_lsb;
    assign unused_imm_lsb = imm[0];
    assign range_ok       = 1'b1;
`endif

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder and instruction-memory loader.
// Ports: clk, rst_n (sync active-low); start/base_addr open a session;
//        in_* command stream (valid/ready, in_last ends session);
//        imem_we/imem_ready/imem_addr/imem_wdata write port;
//        busy, done (1-cycle), word_count, err (sticky per session).
// Config: ENCODER_RANGE_CHECK_EN (see instr_encoder_imm_packer).
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W   = 12,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_op,
    input  logic [2:0]        in_funct3,
    input  logic              in_alt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              err
);

    state_e      state;
    fmt_e        fmt;
    logic        legal;
    logic        range_ok;
    logic [6:0]  funct7;
    logic [31:0] imm_bits;
    logic [31:0] fields;
    logic [31:0] enc_word;
    logic        cmd_bad;
    logic        accept;
    logic        write_done;

    instr_encoder_imm_packer u_imm_packer (
        .fmt      (fmt),
        .imm      (in_imm),
        .imm_bits (imm_bits),
        .range_ok (range_ok)
    );

    // Opcode -> format, plus funct3 legality.
    always_comb begin
        fmt    = FMT_R;
        legal  = 1'b1;
        funct7 = in_alt ? FUNCT7_ALT : FUNCT7_ZERO;
        unique case (in_op)
            OPC_OP:    fmt = FMT_R;
            OPC_OPIMM: fmt = (in_funct3 == F3_SLL || in_funct3 == F3_SRX) ? FMT_ISH : FMT_I;
            OPC_JALR: begin
                fmt   = FMT_I;
                legal = (in_funct3 == 3'b000);
            end
            OPC_LOAD: begin
                fmt   = FMT_I;
                legal = (in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                legal = (in_funct3 < 3'b011);
            end
            OPC_BRANCH: begin
                fmt   = FMT_B;
                legal = (in_funct3 != 3'b010) && (in_funct3 != 3'b011);
            end
            OPC_LUI, OPC_AUIPC: fmt = FMT_U;
            OPC_JAL:            fmt = FMT_J;
            default:            legal = 1'b0;
        endcase
    end

    // Non-immediate fields per format; immediate bits are OR-ed in.
    always_comb begin
        fields = '0;
        unique case (fmt)
            FMT_R:        fields = {funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
            FMT_I:        fields = {12'b0, in_rs1, in_funct3, in_rd, in_op};
            FMT_ISH:      fields = {funct7, 5'b0, in_rs1, in_funct3, in_rd, in_op};
            FMT_S, FMT_B: fields = {7'b0, in_rs2, in_rs1, in_funct3, 5'b0, in_op};
            FMT_U, FMT_J: fields = {20'b0, in_rd, in_op};
            default:      fields = '0;
        endcase
    end

    assign cmd_bad    = !(legal && range_ok);
    assign enc_word   = cmd_bad ? NOP_WORD : (fields | imm_bits);
    assign in_ready   = (state == ST_LOAD) && (!imem_we || imem_ready);
    assign accept     = in_valid && in_ready;
    assign write_done = imem_we && imem_ready;

    // Session FSM, write register and address/word counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_count <= '0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        imem_addr  <= base_addr;
                        word_count <= '0;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD, ST_DRAIN: begin
                    if (write_done) begin
                        imem_addr  <= imem_addr + ADDR_W'(1);
                        word_count <= word_count + (ADDR_W + 1)'(1);
                        if (&imem_addr) err <= 1'b1;
                    end
                    // accept can only fire in LOAD (in_ready gates on it)
                    if (accept) begin
                        imem_we    <= 1'b1;
                        imem_wdata <= enc_word;
                        if (cmd_bad) err <= 1'b1;
                        if (in_last) state <= ST_DRAIN;
                    end else if (write_done) begin
                        imem_we <= 1'b0;
                    end
                    if (state == ST_DRAIN && write_done) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected writes,
// a negedge monitor pops and compares on every completed write.
module tb_instr_encoder;

    localparam int unsigned ADDR_W = 12;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] STORE  = 7'b0100011;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [6:0]        in_op = '0;
    logic [2:0]        in_funct3 = '0;
    logic              in_alt = 1'b0;
    logic [4:0]        in_rd = '0;
    logic [4:0]        in_rs1 = '0;
    logic [4:0]        in_rs2 = '0;
    logic [31:0]       in_imm = '0;
    logic              in_last = 1'b0;
    logic              imem_we;
    logic              imem_ready = 1'b1;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   word_count;
    logic              err;

    instr_encoder #(.ADDR_W(ADDR_W), .NOP_WORD(32'h0000_0013)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_funct3(in_funct3), .in_alt(in_alt), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done),
        .word_count(word_count), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [ADDR_W+31:0] sb_q[$];
    logic [ADDR_W-1:0]  exp_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every completed write must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && imem_we && imem_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h, expected none",
                         imem_addr, imem_wdata);
            end else begin
                logic [ADDR_W+31:0] e;
                e = sb_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(e[ADDR_W+31:32]));
                check("wr_data", imem_wdata, e[31:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic start_session(input logic [ADDR_W-1:0] b);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; exp_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_load", 32'(busy), 32'd1);
        check("err_cleared", 32'(err), 32'd0);
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic alt,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm, input logic last, input logic [31:0] exp);
        in_valid = 1'b1; in_op = op; in_funct3 = f3; in_alt = alt;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
        sb_q.push_back({exp_addr, exp});
        exp_addr = exp_addr + ADDR_W'(1);
    endtask

    task automatic wait_accept();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        check("accept_seen", 32'(ok), 32'd1);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic alt,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic last, input logic [31:0] exp);
        drive(op, f3, alt, rd, rs1, rs2, imm, last, exp);
        wait_accept();
    endtask

    task automatic wait_done(input int exp_count, input logic exp_err);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        check("done_seen", 32'(ok), 32'd1);
        check("word_count", 32'(word_count), 32'(exp_count));
        check("err", 32'(err), 32'(exp_err));
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // addi / add / sw
        start_session(12'h010);
        send(OPIMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0050_0093);
        send(OP,    3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h0020_81B3);
        send(STORE, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0020_A423);
        wait_done(3, 1'b0);

        // lui / srai / beq / jal
        start_session(12'h040);
        send(LUI,    3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0, 32'h1234_52B7);
        send(OPIMM,  3'b101, 1'b1, 5'd4, 5'd4, 5'd0, 32'd3,         1'b0, 32'h4032_5213);
        send(BRANCH, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0, 32'hFE00_0EE3);
        send(JAL,    3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,         1'b1, 32'h0080_00EF);
        wait_done(4, 1'b0);

        // Memory back-pressure on the first write
        start_session(12'h080);
        imem_ready = 1'b0;
        send(OPIMM, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd7, 1'b0, 32'h0070_0113);
        drive(OP, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h0020_81B3);
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_we", 32'(imem_we), 32'd1);
            check("stall_addr", 32'(imem_addr), 32'h080);
            check("stall_wdata", imem_wdata, 32'h0070_0113);
        end
        @(posedge clk); #1;
        imem_ready = 1'b1;
        wait_accept();
        wait_done(2, 1'b0);

        // Illegal opcode and illegal branch funct3
        start_session(12'h100);
        send(7'b1111111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 32'h0000_0013);
        send(BRANCH,     3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0000_0013);
        wait_done(2, 1'b1);
        repeat (3) @(negedge clk);
        check("err_sticky_idle", 32'(err), 32'd1);

        // addi with an immediate that does not fit 12 bits
        start_session(12'h110);
`ifdef ENCODER_RANGE_CHECK_EN
        send(OPIMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b1, 32'h0000_0013);
        wait_done(1, 1'b1);
`else
        send(OPIMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b1, 32'h0000_0093);
        wait_done(1, 1'b0);
`endif

        // Address wrap from 0xFFF to 0x000
        start_session(12'hFFF);
        send(OPIMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0050_0093);
        send(OP,    3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h0020_81B3);
        wait_done(2, 1'b1);

        // Reset in the middle of a session, then a clean session
        start_session(12'h020);
        send(OPIMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0050_0093);
        @(posedge clk); #1;
        check("pre_rst_word_count", 32'(word_count), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_we", 32'(imem_we), 32'd0);
        check("mid_rst_word_count", 32'(word_count), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_addr", 32'(imem_addr), 32'd0);
        rst_n = 1'b1;
        start_session(12'h030);
        send(LUI, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7);
        wait_done(1, 1'b0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- RV32I instruction encoder and instruction-memory loader; the inverse of the instruction decoder.
- Accepts decoded instruction fields (opcode class, funct3, alt bit, register numbers, immediate in the same form the decoder emits) over a valid/ready stream.
- Packs each command into a 32-bit machine word and writes it to consecutive instruction-memory words from a start address.
- Used by the debug/boot path to load programs; round-trip rule: encoding the decoder's outputs for any legal word returns that word.

Parameters:
- ADDR_W, 12, instruction-memory word-address width.
- NOP_WORD, 32'h00000013, substitute word written for an illegal command.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  pulse; begin a load session at base_addr
- base_addr  in  ADDR_W  first word address of the session
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid&&in_ready
- in_op  in  7  opcode, using the `OP/`OPIMM/`LUI/`AUIPC/`JAL/`JALR/`BRANCH/`LOAD/`STORE macros
- in_funct3  in  3  funct3
- in_alt  in  1  1 selects funct7=7'b0100000 (SUB/SRA/SRAI), else 7'b0000000
- in_rd, in_rs1, in_rs2  in  5 each  register numbers
- in_imm  in  32  immediate, decoder form: byte offset for branch/JAL, upper-aligned value for LUI/AUIPC, shamt in [4:0] for shifts
- in_last  in  1  final command of the session
- imem_we  out  1  write request
- imem_ready  in  1  memory accepts write when imem_we&&imem_ready
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded word
- busy  out  1  session active
- done  out  1  one-cycle pulse after the last word is written
- word_count  out  ADDR_W+1  words written this session
- err  out  1  sticky per session; set on illegal command or address wrap

Behaviour:
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, word_count=0, err=0, state=IDLE.
- State machine:
  - IDLE: on start, latch base_addr, clear word_count and err, go to LOAD.
  - LOAD: on acceptance with in_last=1, go to DRAIN.
  - DRAIN: when the last write completes, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored.
- busy=1 in LOAD and DRAIN.
- Single output register: in_ready = (state==LOAD) && (!imem_we || imem_ready).
- Latency: command accepted in cycle N appears on imem_we/imem_wdata/imem_addr in cycle N+1.
- imem_we and all write fields hold stable until imem_ready.
- Back-to-back writes at full throughput when imem_ready=1.
- On each completed write: imem_addr+1, word_count+1.
- Address wraps modulo 2^ADDR_W; a wrap past the all-ones address sets err.
- Encoding by format:
  - R: OP.
  - I: OPIMM, JALR, LOAD. Shifts (funct3 001/101) use funct7 from in_alt and shamt in_imm[4:0].
  - S: STORE.
  - B: BRANCH, imm[12|10:5|4:1|11].
  - U: LUI, AUIPC; uses in_imm[31:12].
  - J: JAL, imm[20|10:1|11|19:12].
- Illegal commands: unknown opcode, or funct3 undefined for that opcode (e.g. BRANCH 010/011, LOAD 011/110/111, STORE ≥011). The word written is NOP_WORD and err is set.
- Unused fields of a format are ignored, not checked.
- Reset mid-session: abort immediately, all outputs return to their reset values, no further writes.

Optional Feature:
- ENCODER_RANGE_CHECK_EN defined:
  - in_imm must be representable in the target format: sign-extended width, even for B/J, in_imm[11:0]==0 for U, in_imm[31:5]==0 for shifts.
  - Violation: write NOP_WORD and set err.
- Undefined: out-of-range bits are silently truncated; err is set only for illegal opcode/funct3 or address wrap.

Decomposition:
- Shared package/header (define.vh): opcode macros, funct3 constants, FUNCT7_ALT=7'b0100000, NOP_WORD default, state encoding.
- Sub-module imm_packer: combinational; format + in_imm produce the scattered immediate bits and a range_ok flag.
- FSM, handshake and address counter stay in instr_encoder.

Test Plan:
- start base_addr=0x010; addi x1,x0,5; add x3,x1,x2; sw x2,8(x1) (last); imem_ready=1 → writes 0x00500093 @0x010, 0x002081B3 @0x011, 0x0020A423 @0x012; done pulse; word_count=3; err=0.
- lui x5,0x12345000; srai x4,x4,3 (alt=1); beq x0,x0,-4 (imm=0xFFFFFFFC); jal x1,+8 → 0x123452B7, 0x40325213, 0xFE000EE3, 0x008000EF.
- imem_ready low for 3 cycles on the first write → imem_we/addr/wdata stable, in_ready=0, no command lost; the following word lands at addr+1.
- in_op=7'b1111111 → NOP 0x00000013 written, err=1 until next start; with ENCODER_RANGE_CHECK_EN, addi imm=4096 → 0x00000013, err=1.
- base_addr=0xFFF (ADDR_W=12), two commands → writes @0xFFF then @0x000, err=1.
- rst_n=0 during LOAD after one write → next cycle busy=0, imem_we=0, word_count=0; a new start works normally.
